// File: rtl/serdes_pkg.sv
// Shared types and defaults for the serdes transmit path.
package serdes_pkg;

  localparam int SER_BITS = 8;
  localparam logic [7:0] SER_IDLE_CHAR = 8'hBC;  // K28.5 comma

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;

  // FIFO entry layout at the default width; ser_fifo2 stores the same {dk, data} packing.
  typedef struct packed {
    logic                dk;
    logic [SER_BITS-1:0] data;
  } ser_word_t;

endpackage

// File: rtl/ser_fifo2.sv
// Two-entry FIFO between the upstream handshake and the serializer shift register.
module ser_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  // Flags come from the registered count, so a push into an empty FIFO is never popped on the same edge.
  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: buffers words in ser_fifo2 and shifts them out MSB-first.
// Define SERIALIZER_IDLE_INSERT_EN to fill gaps with IDLE_CHAR (dk=1); otherwise gaps send zeros (dk=0).
module serializer_tx
  import serdes_pkg::*;
#(
  parameter int               BITS      = SER_BITS,
  parameter logic [BITS-1:0]  IDLE_CHAR = BITS'(SER_IDLE_CHAR)
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [BITS-1:0] in_data,
  input  logic            in_dk,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            data_out,
  output logic            dk_out,
  output logic            frame_start,
  output logic            idle,
  output logic            state_dbg
);

  // Handshake: a word transfers at a rising edge where in_valid && in_ready; in_ready
  // depends only on registered FIFO occupancy, and in_data/in_dk are ignored otherwise.

`ifdef SERIALIZER_IDLE_INSERT_EN
  localparam bit GAP_IDLE = 1'b1;
`else
  localparam bit GAP_IDLE = 1'b0;
`endif
  localparam logic [BITS-1:0] GAP_WORD = GAP_IDLE ? IDLE_CHAR : '0;
  localparam logic            GAP_DK   = GAP_IDLE;
  localparam int              CW       = $clog2(BITS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic            dk_q, dk_d;
  logic            idle_q, idle_d;
  logic            fs_q, fs_d;
  logic            boundary;
  logic [BITS:0]   head;
  logic            fifo_full;
  logic            fifo_empty;

  assign boundary = (cnt_q == CNT_LAST);

  ser_fifo2 #(.W(BITS + 1)) u_fifo (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (in_valid),
    .push_data ({in_dk, in_data}),
    .pop       (boundary),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready    = !fifo_full;
  assign data_out    = shreg_q[BITS-1];
  assign dk_out      = dk_q;
  assign idle        = idle_q;
  assign frame_start = fs_q;
  assign state_dbg   = (state_q == S_DATA);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_LAST;
      shreg_q <= '0;
      dk_q    <= 1'b0;
      idle_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dk_q    <= dk_d;
      idle_q  <= idle_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    shreg_d = {shreg_q[BITS-2:0], 1'b0};
    dk_d    = dk_q;
    idle_d  = idle_q;
    if (boundary) begin
      cnt_d = '0;
      if (!fifo_empty) begin
        shreg_d = head[BITS-1:0];
        dk_d    = head[BITS];
        idle_d  = 1'b0;
        state_d = S_DATA;
      end else begin
        shreg_d = GAP_WORD;
        dk_d    = GAP_DK;
        idle_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
    fs_d = (cnt_d == '0);
  end

endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: word vector table plus back-to-back, no-bypass and mid-word reset sequences.
module tb_serializer_tx;

`ifdef SERIALIZER_IDLE_INSERT_EN
  localparam logic [7:0] GAP_W  = 8'hBC;
  localparam logic       GAP_DK = 1'b1;
`else
  localparam logic [7:0] GAP_W  = 8'h00;
  localparam logic       GAP_DK = 1'b0;
`endif

  logic       clk;
  logic       reset_L;
  logic [7:0] in_data;
  logic       in_dk;
  logic       in_valid;
  logic       in_ready;
  logic       data_out;
  logic       dk_out;
  logic       frame_start;
  logic       idle;
  logic       state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       dk;
    logic [7:0] exp_bits;
    logic       exp_dk;
  } vec_t;

  vec_t vecs [4];

  serializer_tx #(.BITS(8), .IDLE_CHAR(8'hBC)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .in_data     (in_data),
    .in_dk       (in_dk),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .dk_out      (dk_out),
    .frame_start (frame_start),
    .idle        (idle),
    .state_dbg   (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle per bit b = hi..lo and check the bit on the line.
  task automatic frame_check(input logic [7:0] w, input logic dk, input logic idl,
                             input int hi, input int lo, input string tag);
    for (int b = hi; b >= lo; b--) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " data_out"}, 32'(data_out), 32'(w[b]));
      check({tag, " dk_out"}, 32'(dk_out), 32'(dk));
      check({tag, " idle"}, 32'(idle), 32'(idl));
      check({tag, " frame_start"}, 32'(frame_start), 32'(b == 7));
      check({tag, " state"}, 32'(state_dbg), 32'(!idl));
    end
  endtask

  initial begin
    logic [7:0] b2b_w [4];
    logic       b2b_dk [4];
    int         idx;
    logic       hs;
    logic [7:0] shw;
    int         nbits;
    logic       f_dk;
    logic       f_idle;
    int         ndata;
    int         gaps_between;
    logic [8:0] e;

    vecs[0] = '{data: 8'h88, dk: 1'b0, exp_bits: 8'b1000_1000, exp_dk: 1'b0};
    vecs[1] = '{data: 8'h3C, dk: 1'b1, exp_bits: 8'b0011_1100, exp_dk: 1'b1};
    vecs[2] = '{data: 8'h5A, dk: 1'b0, exp_bits: 8'b0101_1010, exp_dk: 1'b0};
    vecs[3] = '{data: 8'h01, dk: 1'b1, exp_bits: 8'b0000_0001, exp_dk: 1'b1};

    reset_L  = 1'b0;
    in_data  = 8'h00;
    in_dk    = 1'b0;
    in_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("rst data_out", 32'(data_out), 0);
    check("rst dk_out", 32'(dk_out), 0);
    check("rst frame_start", 32'(frame_start), 0);
    check("rst idle", 32'(idle), 0);
    check("rst in_ready", 32'(in_ready), 1);
    check("rst state", 32'(state_dbg), 0);

    // Release on a negedge; the next rising edge is a boundary.
    reset_L = 1'b1;
    frame_check(GAP_W, GAP_DK, 1'b1, 7, 0, "idle0");
    frame_check(GAP_W, GAP_DK, 1'b1, 7, 0, "idle1");

    // Each word is pushed on a boundary edge, so it waits one full gap frame (no bypass).
    for (int v = 0; v < 4; v++) begin
      in_valid = 1'b1;
      in_data  = vecs[v].data;
      in_dk    = vecs[v].dk;
      frame_check(GAP_W, GAP_DK, 1'b1, 7, 7, "vec gap");
      in_valid = 1'b0;
      in_data  = 8'hEE;
      check("vec in_ready", 32'(in_ready), 1);
      frame_check(GAP_W, GAP_DK, 1'b1, 6, 0, "vec gap");
      frame_check(vecs[v].exp_bits, vecs[v].exp_dk, 1'b0, 7, 0, "vec word");
    end
    frame_check(GAP_W, GAP_DK, 1'b1, 7, 0, "idle resume");

    // Back-to-back: hold in_valid over four words, scoreboard the serial frames.
    b2b_w[0] = 8'hA1; b2b_dk[0] = 1'b0;
    b2b_w[1] = 8'hB2; b2b_dk[1] = 1'b0;
    b2b_w[2] = 8'hC3; b2b_dk[2] = 1'b0;
    b2b_w[3] = 8'hD4; b2b_dk[3] = 1'b1;
    idx = 0;
    in_valid = 1'b1;
    in_data  = b2b_w[0];
    in_dk    = b2b_dk[0];
    nbits = 0;
    shw = 8'h00;
    f_dk = 1'b0;
    f_idle = 1'b1;
    ndata = 0;
    gaps_between = 0;
    for (int s = 0; s < 48; s++) begin
      hs = in_valid && in_ready;
      if (hs) exp_q.push_back({in_dk, in_data});
      @(posedge clk);
      @(negedge clk);
      if (hs) begin
        idx++;
        if (idx < 4) begin
          in_data = b2b_w[idx];
          in_dk   = b2b_dk[idx];
        end else begin
          in_valid = 1'b0;
          in_data  = 8'h00;
          in_dk    = 1'b0;
        end
      end
      if (s == 1) check("b2b in_ready full", 32'(in_ready), 0);
      if (s == 8) check("b2b in_ready after pop", 32'(in_ready), 1);
      if (s == 9) check("b2b in_ready refull", 32'(in_ready), 0);
      if (frame_start) begin
        nbits  = 1;
        shw    = {7'b0, data_out};
        f_dk   = dk_out;
        f_idle = idle;
      end else begin
        shw = {shw[6:0], data_out};
        nbits++;
      end
      if (nbits == 8) begin
        if (!f_idle) begin
          if (exp_q.size() == 0) begin
            check("b2b unexpected word", 32'(shw), 32'h1FF);
          end else begin
            e = exp_q.pop_front();
            check("b2b word", 32'(shw), 32'(e[7:0]));
            check("b2b dk", 32'(f_dk), 32'(e[8]));
          end
          ndata++;
        end else if (ndata > 0 && ndata < 4) begin
          gaps_between++;
        end
      end
    end
    check("b2b words sent", 32'(ndata), 4);
    check("b2b gaps between", 32'(gaps_between), 0);
    check("b2b queue drained", 32'(exp_q.size()), 0);

    // Mid-word reset: F0 on the line with 77 queued (pushed on the same edge F0 popped).
    in_valid = 1'b1;
    in_data  = 8'hF0;
    in_dk    = 1'b0;
    frame_check(GAP_W, GAP_DK, 1'b1, 7, 7, "rstseq gap");
    in_valid = 1'b0;
    frame_check(GAP_W, GAP_DK, 1'b1, 6, 0, "rstseq gap");
    in_valid = 1'b1;
    in_data  = 8'h77;
    frame_check(8'hF0, 1'b0, 1'b0, 7, 7, "rstseq word");
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("rstseq in_ready one queued", 32'(in_ready), 1);
    frame_check(8'hF0, 1'b0, 1'b0, 6, 4, "rstseq word");
    reset_L = 1'b0;
    #1;
    check("midrst data_out", 32'(data_out), 0);
    check("midrst dk_out", 32'(dk_out), 0);
    check("midrst idle", 32'(idle), 0);
    check("midrst frame_start", 32'(frame_start), 0);
    check("midrst in_ready", 32'(in_ready), 1);
    check("midrst state", 32'(state_dbg), 0);
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    frame_check(GAP_W, GAP_DK, 1'b1, 7, 0, "post rst idle0");
    frame_check(GAP_W, GAP_DK, 1'b1, 7, 0, "post rst idle1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
